// File: rtl/skid_reg.sv
// ---------------------------------------------------------------------------
// skid_reg : two-entry valid/ready pipeline register with fully registered I/O
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skid_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_dat_o,
  output logic [1:0]            cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q,  main_d;
  logic [DATA_WIDTH-1:0] skid_q,  skid_d;
  logic                  in_xfer;
  logic                  out_xfer;

  // Handshake outputs decode state flops only, so no input reaches an output.
  always_comb begin
    s_ready_o = (state_q != FULL);
    m_valid_o = (state_q != EMPTY);
    case (state_q)
      BUSY:    cnt_o = 2'd1;
      FULL:    cnt_o = 2'd2;
      default: cnt_o = 2'd0;
    endcase
  end

  assign m_dat_o  = main_q;
  assign in_xfer  = s_valid_i & s_ready_o;
  assign out_xfer = m_valid_o & m_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = s_dat_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = s_dat_i;
        end else if (in_xfer) begin
          skid_d  = s_dat_i;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops every held entry; payload registers simply keep their contents.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_skid_reg : randomized queue-model bench for skid_reg (32-bit and 1-bit)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_skid_reg;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         flush_i, s_valid_i, m_ready_i;
  logic [W-1:0] s_dat_i;
  logic         s_ready_o, m_valid_o;
  logic [W-1:0] m_dat_o;
  logic [1:0]   cnt_o;

  logic         flush1_i, s_valid1_i, m_ready1_i;
  logic [0:0]   s_dat1_i;
  logic         s_ready1_o, m_valid1_o;
  logic [0:0]   m_dat1_o;
  logic [1:0]   cnt1_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mdl_q[$];
  logic         mdl1_q[$];
  logic         hold, hold1;
  logic [W-1:0] hold_dat;
  logic         hold1_dat;

  always #5 clk_i = ~clk_i;

  skid_reg #(.DATA_WIDTH(W)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_dat_i(s_dat_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_dat_o(m_dat_o),
    .cnt_o(cnt_o)
  );

  skid_reg #(.DATA_WIDTH(1)) u_dut1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush1_i),
    .s_valid_i(s_valid1_i), .s_ready_o(s_ready1_o), .s_dat_i(s_dat1_i),
    .m_valid_o(m_valid1_o), .m_ready_i(m_ready1_i), .m_dat_o(m_dat1_o),
    .cnt_o(cnt1_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the queue models at the falling edge,
  // then advance the models with whatever the handshake rules say moved.
  task automatic cycle();
    bit         in0, out0, in1, out1, fl0, fl1;
    logic [W-1:0] d0;
    logic         d1;
    @(negedge clk_i);
    check_eq("cnt",     {30'd0, cnt_o}, mdl_q.size());
    check_eq("m_valid", {31'd0, m_valid_o}, {31'd0, mdl_q.size() > 0});
    check_eq("s_ready", {31'd0, s_ready_o}, {31'd0, mdl_q.size() < 2});
    if (mdl_q.size() > 0) check_eq("m_dat", m_dat_o, mdl_q[0]);
    if (hold) check_eq("stable", m_dat_o, hold_dat);
    check_eq("cnt_w1",     {30'd0, cnt1_o}, mdl1_q.size());
    check_eq("m_valid_w1", {31'd0, m_valid1_o}, {31'd0, mdl1_q.size() > 0});
    check_eq("s_ready_w1", {31'd0, s_ready1_o}, {31'd0, mdl1_q.size() < 2});
    if (mdl1_q.size() > 0) check_eq("m_dat_w1", {31'd0, m_dat1_o}, {31'd0, mdl1_q[0]});
    if (hold1) check_eq("stable_w1", {31'd0, m_dat1_o}, {31'd0, hold1_dat});

    in0  = s_valid_i && (mdl_q.size() < 2);
    out0 = m_ready_i && (mdl_q.size() > 0);
    in1  = s_valid1_i && (mdl1_q.size() < 2);
    out1 = m_ready1_i && (mdl1_q.size() > 0);
    fl0  = flush_i;
    fl1  = flush1_i;
    d0   = s_dat_i;
    d1   = s_dat1_i[0];
    hold      = (mdl_q.size() > 0) && !m_ready_i && !flush_i;
    hold_dat  = (mdl_q.size() > 0) ? mdl_q[0] : '0;
    hold1     = (mdl1_q.size() > 0) && !m_ready1_i && !flush1_i;
    hold1_dat = (mdl1_q.size() > 0) ? mdl1_q[0] : 1'b0;

    @(posedge clk_i);
    #1;
    if (fl0) mdl_q.delete();
    else begin
      if (out0) void'(mdl_q.pop_front());
      if (in0) mdl_q.push_back(d0);
    end
    if (fl1) mdl1_q.delete();
    else begin
      if (out1) void'(mdl1_q.pop_front());
      if (in1) mdl1_q.push_back(d1);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 0; s_valid_i = 0; m_ready_i = 0; s_dat_i = '0;
    flush1_i = 0; s_valid1_i = 0; m_ready1_i = 0; s_dat1_i = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    check_eq("rst_s_ready", {31'd0, s_ready_o}, 32'd1);
    check_eq("rst_cnt",     {30'd0, cnt_o}, 32'd0);
    check_eq("rst_m_dat",   m_dat_o, 32'd0);
    check_eq("rst_cnt_w1",  {30'd0, cnt1_o}, 32'd0);
    check_eq("rst_m_dat_w1", {31'd0, m_dat1_o}, 32'd0);
    mdl_q.delete();
    mdl1_q.delete();
    hold = 0;
    hold1 = 0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    hold = 0; hold1 = 0; hold_dat = '0; hold1_dat = 1'b0;
    idle_inputs();
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    async_reset();
    cycle();

    // Streaming at full rate
    for (int i = 1; i <= 100; i++) begin
      s_valid_i = 1; m_ready_i = 1; s_dat_i = W'(i);
      cycle();
    end
    s_valid_i = 0;
    cycle();
    cycle();

    // Stall with A, B held and C offered
    m_ready_i = 0;
    s_valid_i = 1; s_dat_i = 'hA; cycle();
    s_dat_i = 'hB; cycle();
    s_dat_i = 'hC;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_head", m_dat_o, 32'hA);
      check_eq("stall_cnt", {30'd0, cnt_o}, 32'd2);
    end
    m_ready_i = 1;
    cycle();
    check_eq("drain_2nd", m_dat_o, 32'hB);
    cycle();
    s_valid_i = 0;
    check_eq("drain_3rd", m_dat_o, 32'hC);
    cycle();
    cycle();

    // Flush from FULL with an accepted-but-dropped beat
    m_ready_i = 0;
    s_valid_i = 1; s_dat_i = 'h11; cycle();
    s_dat_i = 'h22; cycle();
    check_eq("pre_flush_cnt", {30'd0, cnt_o}, 32'd2);
    flush_i = 1; s_dat_i = 'h33; cycle();
    flush_i = 0; s_valid_i = 0;
    check_eq("flush_valid", {31'd0, m_valid_o}, 32'd0);
    check_eq("flush_cnt", {30'd0, cnt_o}, 32'd0);
    check_eq("flush_ready", {31'd0, s_ready_o}, 32'd1);
    m_ready_i = 1;
    cycle();
    cycle();

    // Random traffic on both widths, with one mid-run async reset
    for (int i = 0; i < 10000; i++) begin
      s_valid_i  = $urandom_range(0, 1);
      m_ready_i  = $urandom_range(0, 1);
      s_dat_i    = $urandom;
      flush_i    = ($urandom_range(0, 63) == 0);
      s_valid1_i = $urandom_range(0, 1);
      m_ready1_i = $urandom_range(0, 1);
      s_dat1_i   = 1'(i);
      cycle();
      if (i == 5000) begin
        s_valid_i = 1; m_ready_i = 0; flush_i = 0;
        cycle();
        async_reset();
      end
    end

    idle_inputs();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
